rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with burst locking. It shares one downstream resource port (e.g. a shared memory or writeback port) between NUM_REQ requesters.
- Issues a registered one-hot grant plus its binary index.
- Holds the grant for the whole burst, releasing only on an accepted last beat.
- Sits between the warp/lane requesters and the shared resource. The binary index drives the resource-side mux select and the response ID.

Parameters:
- NUM_REQ, 4, number of requesters (>=2, need not be a power of two)
- ID_WIDTH, 2, width of binary grant index; must satisfy 2**ID_WIDTH >= NUM_REQ

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_i  input  NUM_REQ  per-requester request, level-sensitive
- gnt_o  output  NUM_REQ  registered one-hot grant, all-zero when idle
- gnt_id_o  output  ID_WIDTH  registered binary index of the granted requester
- gnt_valid_o  output  1  grant active; downstream transfer valid
- out_ready_i  input  1  downstream accepts the current beat
- out_last_i  input  1  current beat is the last of the burst (muxed from the granted requester)
- ptr_o  output  ID_WIDTH  current round-robin priority pointer (debug/verification)

Behaviour:
- Reset (sampled at posedge with rst=1):
  - gnt_o=0, gnt_id_o=0, gnt_valid_o=0, ptr=0, state=IDLE.
  - Reset during a locked burst drops the grant in the next cycle with no release handshake.
- State IDLE (gnt_valid_o=0):
  - If |req_i, select the first requester with req_i=1 searching from index ptr upward, wrapping NUM_REQ-1 -> 0.
  - Register gnt_o (one-hot of the winner), gnt_id_o (its binary index) and gnt_valid_o=1; go to LOCK.
  - Latency: req_i asserted in cycle t -> gnt_valid_o=1 in cycle t+1.
  - If req_i=0, stay in IDLE.
- State LOCK (gnt_valid_o=1):
  - gnt_o and gnt_id_o are held constant. req_i is ignored for the duration of the lock, including deassertion by the owner.
  - A beat transfers when gnt_valid_o & out_ready_i.
  - A transfer with out_last_i=0 keeps the lock.
  - out_last_i is ignored when out_ready_i=0.
- Release (a transfer with out_last_i=1):
  - ptr <= (gnt_id_o==NUM_REQ-1) ? 0 : gnt_id_o+1.
  - In the same cycle, arbitrate req_i using the updated pointer value, computed combinationally from gnt_id_o.
  - If any request exists, register the new grant with zero bubble (gnt_valid_o stays 1) and remain in LOCK.
  - Otherwise clear gnt_o and gnt_valid_o, keep gnt_id_o, and go to IDLE.
  - The releasing requester may win again only if it is the sole requester, since it has lowest priority.
- Invariants:
  - gnt_o is zero or exactly one-hot.
  - gnt_o[gnt_id_o]==1 whenever gnt_valid_o=1.
  - gnt_o is a subset of the req_i value sampled at grant time.
- Fairness: with all requesters continuously requesting, grant order is strictly cyclic. Any requester is served within NUM_REQ-1 bursts of others.
- Single-beat bursts: out_last_i=1 on the first accepted beat gives one grant per cycle under continuous ready.
- Requester indices >= NUM_REQ never appear on gnt_id_o.
- ptr updates only on release or reset.

Test Plan:
- Reset then req_i=4'b0000 for 5 cycles -> gnt_valid_o=0, gnt_o=0, ptr_o=0 throughout.
- req_i=4'b1010 at cycle 1, out_ready_i=1, out_last_i=1 on every beat -> grants at cycles 2,3,4,5 are id 1,3,1,3 (gnt_o 0010,1000,0010,1000), with no idle cycle between.
- req_i=4'b1111, each burst 3 beats, out_ready_i toggling 1,0,1,0... -> ids 0,1,2,3,0 in order.
  - Each grant is held until the third accepted beat; gnt_id_o is constant while out_ready_i=0.
- Owner 2 locked, drops req_i[2] mid-burst while req_i[0] asserts -> grant stays 0100 until last beat accepted.
  - Next cycle gnt_o=0001, ptr_o=3 during that grant.
- NUM_REQ=3, ID_WIDTH=2, req_i=3'b111, single-beat bursts -> ids 0,1,2,0,1; ptr_o wraps 2->0, never shows 3.
- rst=1 asserted while locked on id 2 mid-burst -> next cycle gnt_o=0, gnt_valid_o=0, ptr_o=0.
  - After rst=0 with req_i=4'b0100, the grant goes to id 2 one cycle later.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with burst locking for one shared downstream port.
// A grant is held until the burst's last beat is accepted; re-arbitration on release has zero bubble.
module rr_lock_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                gnt_valid_o,
    input  logic                out_ready_i,
    input  logic                out_last_i,
    output logic [ID_WIDTH-1:0] ptr_o
);

    localparam logic [0:0]          ST_IDLE = 1'b0;
    localparam logic [0:0]          ST_LOCK = 1'b1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH-1:0] ONE_ID  = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] ZERO_ID = {ID_WIDTH{1'b0}};

    // Returns {found, id}: first requester at or above start, else the lowest requester overall.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [ID_WIDTH-1:0] start);
        logic [NUM_REQ-1:0]  hi;
        logic [NUM_REQ-1:0]  pool;
        logic [ID_WIDTH-1:0] id;
        for (int j = 0; j < NUM_REQ; j++) begin
            hi[j] = req[j] & (j >= int'(start));
        end
        pool = (|hi) ? hi : req;
        id   = ZERO_ID;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            id = pool[j] ? ID_WIDTH'(j) : id;
        end
        return {|req, id};
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_REQ-1:0] oh;
        for (int j = 0; j < NUM_REQ; j++) begin
            oh[j] = (int'(id) == j);
        end
        return oh;
    endfunction

    logic [0:0]          state_r,     state_nxt_s;
    logic [ID_WIDTH-1:0] ptr_r,       ptr_nxt_s;
    logic [NUM_REQ-1:0]  gnt_r,       gnt_nxt_s;
    logic [ID_WIDTH-1:0] gnt_id_r,    gnt_id_nxt_s;
    logic                gnt_valid_r, gnt_valid_nxt_s;

    logic                release_s;
    logic [ID_WIDTH-1:0] next_ptr_s;
    logic [ID_WIDTH-1:0] search_start_s;
    logic                pick_found_s;
    logic [ID_WIDTH-1:0] pick_id_s;

    // Arbitration and lock/release next-state logic
    always_comb begin
        release_s       = gnt_valid_r & out_ready_i & out_last_i;
        next_ptr_s      = (gnt_id_r == LAST_ID) ? ZERO_ID : (gnt_id_r + ONE_ID);
        // On release the search must already start past the releasing owner.
        search_start_s  = release_s ? next_ptr_s : ptr_r;
        {pick_found_s, pick_id_s} = rr_pick(req_i, search_start_s);

        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        gnt_nxt_s       = gnt_r;
        gnt_id_nxt_s    = gnt_id_r;
        gnt_valid_nxt_s = gnt_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    gnt_nxt_s       = to_onehot(pick_id_s);
                    gnt_id_nxt_s    = pick_id_s;
                    gnt_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_LOCK;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (release_s) begin
                    ptr_nxt_s = next_ptr_s;
                    if (pick_found_s) begin
                        gnt_nxt_s       = to_onehot(pick_id_s);
                        gnt_id_nxt_s    = pick_id_s;
                        gnt_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_LOCK;
                    end else begin
                        gnt_nxt_s       = {NUM_REQ{1'b0}};
                        gnt_valid_nxt_s = 1'b0;
                        state_nxt_s     = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: begin
                gnt_nxt_s       = {NUM_REQ{1'b0}};
                gnt_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= ZERO_ID;
            gnt_r       <= {NUM_REQ{1'b0}};
            gnt_id_r    <= ZERO_ID;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
        end
    end

    assign gnt_o       = gnt_r;
    assign gnt_id_o    = gnt_id_r;
    assign gnt_valid_o = gnt_valid_r;
    assign ptr_o       = ptr_r;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: a 4-requester and a 3-requester instance.
// Stimulus pushes expected grants; monitors pop and compare on every new grant.
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, gnt;
    logic       ready, last, gnt_valid;
    logic [1:0] gnt_id, ptr;
    logic [2:0] req3, gnt3;
    logic       ready3, last3, gnt_valid3;
    logic [1:0] gnt_id3, ptr3;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] gnt;
        logic [1:0] ptr;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    rr_lock_arbiter #(.NUM_REQ(4), .ID_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .gnt_id_o(gnt_id),
        .gnt_valid_o(gnt_valid), .out_ready_i(ready), .out_last_i(last), .ptr_o(ptr)
    );

    rr_lock_arbiter #(.NUM_REQ(3), .ID_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .gnt_o(gnt3), .gnt_id_o(gnt_id3),
        .gnt_valid_o(gnt_valid3), .out_ready_i(ready3), .out_last_i(last3), .ptr_o(ptr3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [1:0] id, input logic [3:0] g, input logic [1:0] p);
        exp_t e;
        e.id = id; e.gnt = g; e.ptr = p;
        q4.push_back(e);
    endtask

    task automatic push3(input logic [1:0] id, input logic [2:0] g, input logic [1:0] p);
        exp_t e;
        e.id = id; e.gnt = {1'b0, g}; e.ptr = p;
        q3.push_back(e);
    endtask

    // Monitor for the 4-requester instance
    initial begin : mon4
        logic prev_v, prev_rel;
        exp_t e;
        prev_v = 1'b0; prev_rel = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid && (!prev_v || prev_rel)) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant4_unexpected: got id %0d gnt %b, expected no grant at %0t", gnt_id, gnt, $time);
                end else begin
                    e = q4.pop_front();
                    check("grant4_id",  32'(gnt_id), 32'(e.id));
                    check("grant4_gnt", 32'(gnt),    32'(e.gnt));
                    check("grant4_ptr", 32'(ptr),    32'(e.ptr));
                end
            end
            if (gnt_valid) check("onehot4", 32'(gnt), 32'(4'b0001 << gnt_id));
            else           check("idle_gnt4", 32'(gnt), 32'd0);
            prev_v   = gnt_valid;
            prev_rel = gnt_valid & ready & last & !rst;
        end
    end

    // Monitor for the 3-requester instance
    initial begin : mon3
        logic prev_v, prev_rel;
        exp_t e;
        prev_v = 1'b0; prev_rel = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid3 && (!prev_v || prev_rel)) begin
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant3_unexpected: got id %0d gnt %b, expected no grant at %0t", gnt_id3, gnt3, $time);
                end else begin
                    e = q3.pop_front();
                    check("grant3_id",  32'(gnt_id3),       32'(e.id));
                    check("grant3_gnt", 32'({1'b0, gnt3}),  32'(e.gnt));
                    check("grant3_ptr", 32'(ptr3),          32'(e.ptr));
                end
            end
            check("range3_ptr", 32'(ptr3 < 2'd3), 32'd1);
            check("range3_id",  32'(gnt_id3 < 2'd3), 32'd1);
            prev_v   = gnt_valid3;
            prev_rel = gnt_valid3 & ready3 & last3 & !rst;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int burst, beats;
        logic rdy_phase;
        logic [1:0] exp_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1; req = 4'b0000; ready = 1'b0; last = 1'b0;
        req3 = 3'b000; ready3 = 1'b0; last3 = 1'b0;
        step(); step();
        rst = 1'b0;

        // Idle after reset
        repeat (5) begin
            @(negedge clk);
            check("t0_valid", 32'(gnt_valid), 32'd0);
            check("t0_gnt",   32'(gnt),       32'd0);
            check("t0_ptr",   32'(ptr),       32'd0);
        end

        // Two requesters, single-beat bursts, back-to-back
        step();
        req = 4'b1010; ready = 1'b1; last = 1'b1;
        push4(2'd1, 4'b0010, 2'd0);
        push4(2'd3, 4'b1000, 2'd2);
        push4(2'd1, 4'b0010, 2'd0);
        push4(2'd3, 4'b1000, 2'd2);
        repeat (3) begin
            step();
            @(negedge clk);
            check("t1_no_bubble", 32'(gnt_valid), 32'd1);
        end
        step();
        req = 4'b0000;
        @(negedge clk);
        check("t1_no_bubble", 32'(gnt_valid), 32'd1);
        step();
        ready = 1'b0; last = 1'b0;
        @(negedge clk);
        check("t1_idle_valid", 32'(gnt_valid), 32'd0);
        check("t1_idle_gnt",   32'(gnt),       32'd0);
        check("t1_keep_id",    32'(gnt_id),    32'd3);
        check("t1_idle_ptr",   32'(ptr),       32'd0);

        // All requesting, 3-beat bursts, ready toggling
        step();
        req = 4'b1111; ready = 1'b0; last = 1'b0;
        push4(2'd0, 4'b0001, 2'd0);
        push4(2'd1, 4'b0010, 2'd1);
        push4(2'd2, 4'b0100, 2'd2);
        push4(2'd3, 4'b1000, 2'd3);
        push4(2'd0, 4'b0001, 2'd0);
        step();
        burst = 0; beats = 0; rdy_phase = 1'b1;
        while (burst < 5) begin
            ready = rdy_phase;
            last  = rdy_phase && (beats == 2);
            if (burst == 4) req = 4'b0000;
            @(negedge clk);
            check("t2_hold_id",    32'(gnt_id),    32'(exp_ids[burst]));
            check("t2_hold_valid", 32'(gnt_valid), 32'd1);
            step();
            if (ready) begin
                if (beats == 2) begin
                    beats = 0;
                    burst++;
                end else begin
                    beats++;
                end
            end
            rdy_phase = !rdy_phase;
        end
        ready = 1'b0; last = 1'b0;
        @(negedge clk);
        check("t2_idle_valid", 32'(gnt_valid), 32'd0);
        check("t2_idle_ptr",   32'(ptr),       32'd1);

        // Owner drops its request mid-burst; lock must hold
        step();
        req = 4'b0100;
        push4(2'd2, 4'b0100, 2'd1);
        step();
        req = 4'b0001; ready = 1'b1; last = 1'b0;
        @(negedge clk);
        check("t3_hold_a", 32'(gnt), 32'(4'b0100));
        step();
        ready = 1'b0;
        @(negedge clk);
        check("t3_hold_b", 32'(gnt), 32'(4'b0100));
        step();
        ready = 1'b1; last = 1'b1;
        push4(2'd0, 4'b0001, 2'd3);
        @(negedge clk);
        check("t3_hold_c", 32'(gnt), 32'(4'b0100));
        step();
        req = 4'b0000;
        @(negedge clk);
        check("t3_next_gnt", 32'(gnt), 32'(4'b0001));
        check("t3_next_ptr", 32'(ptr), 32'd3);
        step();
        ready = 1'b0; last = 1'b0;
        @(negedge clk);
        check("t3_idle_valid", 32'(gnt_valid), 32'd0);
        check("t3_idle_ptr",   32'(ptr),       32'd1);

        // Reset in the middle of a locked burst
        step();
        req = 4'b0100;
        push4(2'd2, 4'b0100, 2'd1);
        step();
        ready = 1'b1; last = 1'b0;
        step();
        rst = 1'b1; ready = 1'b0;
        step();
        rst = 1'b0;
        push4(2'd2, 4'b0100, 2'd0);
        @(negedge clk);
        check("t4_rst_gnt",   32'(gnt),       32'd0);
        check("t4_rst_valid", 32'(gnt_valid), 32'd0);
        check("t4_rst_ptr",   32'(ptr),       32'd0);
        check("t4_rst_id",    32'(gnt_id),    32'd0);
        step();
        req = 4'b0000; ready = 1'b1; last = 1'b1;
        @(negedge clk);
        check("t4_regrant", 32'(gnt), 32'(4'b0100));
        step();
        ready = 1'b0; last = 1'b0;

        // Non-power-of-two requester count, pointer wrap
        req3 = 3'b111; ready3 = 1'b1; last3 = 1'b1;
        push3(2'd0, 3'b001, 2'd0);
        push3(2'd1, 3'b010, 2'd1);
        push3(2'd2, 3'b100, 2'd2);
        push3(2'd0, 3'b001, 2'd0);
        push3(2'd1, 3'b010, 2'd1);
        repeat (5) step();
        req3 = 3'b000;
        step();
        ready3 = 1'b0; last3 = 1'b0;
        @(negedge clk);
        check("t5_idle_valid", 32'(gnt_valid3), 32'd0);
        check("t5_idle_ptr",   32'(ptr3),       32'd2);

        repeat (3) step();
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
